// File: rtl/pq_pkg.sv
// Shared types for the hardware priority queue (HWPQ) family and its front ends.
// A smaller key means higher priority (min-queue); KV_EMPTY marks "no pair".
package pq_pkg;

  localparam int KEY_W       = 8;
  localparam int VAL_W       = 8;
  localparam int PQ_CAPACITY = 15;
  localparam bit MIN_PQ      = 1'b1;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: {KEY_W{1'b1}}, val: {VAL_W{1'b0}}};

  typedef enum logic {PQ_OP_ENQ, PQ_OP_DEQ} pq_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } pq_arb_state_t;

  // Successor of a round-robin index among n slots, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pq_arbiter_rr_arb.sv
// Combinational round-robin picker: grants the first set request bit at or
// after ptr, scanning cyclically over NREQ slots.
module rr_arb #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ and i < NREQ, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin front end sharing one HWPQ among NREQ requesters. One request is
// in flight at a time; each accepted request yields a one-cycle response strobe.
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_deq,
  input  kv_t  [NREQ-1:0] req_kv,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] resp_valid,
  output kv_t             resp_kv,
  output logic            resp_err,
  output logic            pq_enq,
  output logic            pq_deq,
  output kv_t             pq_kvi,
  input  kv_t             pq_kvo,
  input  logic            pq_busy,
  input  logic            pq_full,
  input  logic            pq_empty
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  pq_arb_state_t state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  pq_op_t        op_q;
  logic          accept;
  logic          issue_err;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // No handshake may complete while reset is held, or the request would be lost.
  always_comb begin
    accept    = (state == ARB_IDLE) && pick_any && !rst;
    issue_err = (op_q == PQ_OP_ENQ) ? pq_full : pq_empty;
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    pq_enq     = 1'b0;
    pq_deq     = 1'b0;
    if (accept) begin
      req_ready[pick_idx] = 1'b1;
    end
    if (state == ARB_RESP) begin
      resp_valid[gnt_q] = 1'b1;
    end
    if ((state == ARB_ISSUE) && !issue_err) begin
      pq_enq = (op_q == PQ_OP_ENQ);
      pq_deq = (op_q == PQ_OP_DEQ);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (accept) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = issue_err ? ARB_RESP : ARB_WAIT;
      ARB_WAIT:  if (!pq_busy) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      op_q     <= PQ_OP_ENQ;
      resp_err <= 1'b0;
      resp_kv  <= KV_EMPTY;
      pq_kvi   <= KV_EMPTY;
    end else begin
      state <= state_nxt;
      case (state)
        ARB_IDLE: begin
          if (accept) begin
            gnt_q    <= pick_idx;
            op_q     <= req_deq[pick_idx] ? PQ_OP_DEQ : PQ_OP_ENQ;
            pq_kvi   <= req_deq[pick_idx] ? KV_EMPTY : req_kv[pick_idx];
            resp_err <= 1'b0;
            resp_kv  <= KV_EMPTY;
          end
        end
        ARB_ISSUE: begin
          resp_err <= issue_err;
          // pq_kvo is a live peek of the head; grab it before the pop lands
          if ((op_q == PQ_OP_DEQ) && !issue_err) begin
            resp_kv <= pq_kvo;
          end
        end
        ARB_RESP: begin
          rr_ptr <= IW'(rr_next(int'(gnt_q), NREQ));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pq_arbiter.md
# pq_arbiter

Shares a single hardware priority queue among NREQ independent requesters. It accepts enqueue and dequeue requests over per-requester valid/ready handshakes and picks one requester at a time by round-robin. It sequences that request onto the queue's standard enq/deq/busy interface and returns a per-requester response. It sits between client logic and any HWPQ implementation built on pq_pkg.

## Interface
- NREQ, 4, number of requesters (2..16)
- IW, $clog2(NREQ), requester index width (derived, not overridden)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_deq  in  NREQ  per-requester op: 1 = dequeue, 0 = enqueue
- req_kv  in  NREQ x kv_t  per-requester enqueue payload (ignored for dequeue)
- req_ready  out  NREQ  one-hot accept strobe; the handshake completes when req_valid[i] and req_ready[i] are both high
- resp_valid  out  NREQ  one-hot, one-cycle response strobe
- resp_kv  out  kv_t  dequeued pair; KV_EMPTY for enqueue or error
- resp_err  out  1  qualifies resp_valid: enqueue when full or dequeue when empty, no queue op performed
- pq_enq  out  1  one-cycle enqueue pulse to the queue
- pq_deq  out  1  one-cycle dequeue pulse to the queue
- pq_kvi  out  kv_t  enqueue payload, held stable from the issue cycle until the response
- pq_kvo  in  kv_t  current queue head (combinational peek)
- pq_busy  in  1  queue is mid-operation
- pq_full, pq_empty  in  1  queue status

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, grant the first valid index at or after rr_ptr (cyclic).
  - Assert req_ready[g] combinationally in that cycle.
  - Latch g, op and kv, then go to ISSUE.
  - With no request pending, stay in IDLE.
- **ISSUE**
  - Sample pq_full and pq_empty.
  - Enqueue while full, or dequeue while empty: set err, go to RESP.
  - Enqueue otherwise: pq_enq=1 and pq_kvi=latched kv; go to WAIT.
  - Dequeue otherwise: pq_deq=1 and capture pq_kvo into the response register; go to WAIT.
- **WAIT**: go to RESP when pq_busy==0, otherwise stay in WAIT. This state lasts at least one cycle.
- **RESP**
  - resp_valid[g]=1; resp_err and resp_kv hold valid data.
  - rr_ptr <= (g+1) mod NREQ; go to IDLE.
- Only one request is in flight at a time, so req_ready is all-zero outside IDLE.
- A requester that keeps req_valid high after its response competes again, starting from the updated rr_ptr. This guarantees fairness: any continuously valid requester is served within NREQ grants.
- Requesters may change req_deq/req_kv freely except in the accept cycle.

## Timing
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_err=0, pq_enq=0, pq_deq=0, pq_kvi=KV_EMPTY, resp_kv=KV_EMPTY.
- Latency from accept cycle t: issue at t+1, earliest WAIT exit at t+2, response at t+3. Each extra cycle of pq_busy adds one cycle.
- Error path: accept at t, response at t+2.
- Peak throughput: one op every 4 cycles, since IDLE is re-entered at t+4.
- pq_enq and pq_deq are never both high and are never asserted outside ISSUE.
- Reset asserted mid-operation returns to IDLE immediately, with no response and no further pulses. The queue is reset by the same rst.
- rr_ptr wraps from NREQ-1 to 0. When NREQ is not a power of 2, indices ≥ NREQ never occur.

## Structure
- Add to pq_pkg: typedef enum logic {PQ_OP_ENQ, PQ_OP_DEQ} pq_op_t, and the state enum pq_arb_state_t.
- Sub-module rr_arb: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are the grant index and an any-grant flag. It is parameterised by NREQ so other shared-queue blocks can reuse it.

## Test plan
- **Single enqueue**: requester 0 enqueues {K=3,V=5} into an empty queue. Expect req_ready[0] at t, pq_enq at t+1, resp_valid[0] at t+3 with err=0 and resp_kv=KV_EMPTY.
- **Dequeue from empty**: requester 2 dequeues from an empty queue. Expect resp_valid[2] at t+2, resp_err=1, resp_kv=KV_EMPTY, and no pq_deq pulse.
- **Round-robin order**: all four requesters held valid starting with rr_ptr=0. Expect grants in order 0,1,2,3,0, with each resp_valid one-hot and matching its grant.
- **Min ordering**: enqueue keys 7, 2, 9, then dequeue three times. Expect resp_kv keys 2, 7, 9 (MIN_PQ). A fourth dequeue returns err=1.
- **Full and busy stretch**: fill to PQ_CAPACITY=15; the next enqueue gets err=1. Separately, hold pq_busy for 3 cycles after a pulse; the response must slip exactly 3 cycles.
- **Reset mid-op**: assert rst during WAIT. The next cycle shows all outputs at reset values and no resp_valid; after release the first grant goes to requester 0.
